// File: rtl/playfield_pixel_pipe_pkg.sv
// Shared display types and colours for the playfield and the other pixel drivers.
// Contents: playfield geometry defaults, tile_type_t, the tile colour palette,
// and the clear-animation state enum.
package playfield_pixel_pipe_pkg;

   localparam int unsigned PLAYFIELD_ROWS = 20;
   localparam int unsigned PLAYFIELD_COLS = 10;
   localparam int unsigned TILE_WIDTH     = 20;
   localparam int unsigned TILE_HEIGHT    = 20;

   typedef enum logic [3:0] {
      TT_BLANK, TT_GARBAGE, TT_GHOST, TT_I, TT_O, TT_T, TT_J, TT_L, TT_S, TT_Z
   } tile_type_t;

   localparam logic [23:0] TILE_BLANK_COLOR   = 24'h000000;
   localparam logic [23:0] TILE_GARBAGE_COLOR = 24'h808080;
   localparam logic [23:0] TILE_GHOST_COLOR   = 24'h404040;
   localparam logic [23:0] TETROMINO_I_COLOR  = 24'h00ffff;
   localparam logic [23:0] TETROMINO_O_COLOR  = 24'hffff00;
   localparam logic [23:0] TETROMINO_T_COLOR  = 24'ha000f0;
   localparam logic [23:0] TETROMINO_J_COLOR  = 24'h0000ff;
   localparam logic [23:0] TETROMINO_L_COLOR  = 24'hff8000;
   localparam logic [23:0] TETROMINO_S_COLOR  = 24'h00ff00;
   localparam logic [23:0] TETROMINO_Z_COLOR  = 24'hff0000;
   localparam logic [23:0] TILE_FLASH_COLOR   = 24'hffffff;
   localparam logic [23:0] TILE_GRID_COLOR    = 24'h202020;

   typedef enum logic [1:0] {IDLE, FLASH, DONE} clear_state_t;

endpackage

// File: rtl/playfield_pixel_pipe_tile_color_lut.sv
// Combinational tile-type to colour map, shared with the next-piece and hold drivers.
// Ports:
//   tile  - tile type to render
//   color - 24-bit RGB colour; unknown encodings render as blank
module tile_color_lut
   import playfield_pixel_pipe_pkg::*;
(
   input  tile_type_t  tile,
   output logic [23:0] color
);

   always_comb begin
      color = TILE_BLANK_COLOR;
      case (tile)
         TT_GARBAGE: color = TILE_GARBAGE_COLOR;
         TT_GHOST:   color = TILE_GHOST_COLOR;
         TT_I:       color = TETROMINO_I_COLOR;
         TT_O:       color = TETROMINO_O_COLOR;
         TT_T:       color = TETROMINO_T_COLOR;
         TT_J:       color = TETROMINO_J_COLOR;
         TT_L:       color = TETROMINO_L_COLOR;
         TT_S:       color = TETROMINO_S_COLOR;
         TT_Z:       color = TETROMINO_Z_COLOR;
         default:    color = TILE_BLANK_COLOR;
      endcase
   end

endmodule

// File: rtl/playfield_pixel_pipe.sv
// Pipelined playfield renderer with a frame-synchronous line-clear flash.
// Scan position is tracked with tile row/column counters; colour and active flag
// come out two clocks after the matching VGA_row/VGA_col.
// Optional macro PLAYFIELD_GRID_LINES_EN draws grid lines on the last pixel row and
// column of every tile, taking priority over flash and tile colour.
// Ports:
//   clk, rst_l          - pixel clock, asynchronous active-low reset
//   VGA_row, VGA_col    - current scan position
//   frame_start         - one-cycle pulse at the start of each frame
//   tile_type           - playfield contents
//   clear_rows          - rows to flash, latched on clear_start
//   clear_start         - begin clear animation
//   clear_busy          - animation in progress
//   clear_done          - one-cycle pulse at animation end
//   output_color, active- registered pixel colour and in-playfield flag
module playfield_pixel_pipe
   import playfield_pixel_pipe_pkg::*;
#(
   parameter int unsigned HSTART        = 220,
   parameter int unsigned VSTART        = 40,
   parameter int unsigned ROWS          = PLAYFIELD_ROWS,
   parameter int unsigned COLS          = PLAYFIELD_COLS,
   parameter int unsigned TILE_W        = TILE_WIDTH,
   parameter int unsigned TILE_H        = TILE_HEIGHT,
   parameter int unsigned FLASH_PERIOD  = 8,
   parameter int unsigned FLASH_TOGGLES = 6
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic [9:0]       VGA_row,
   input  logic [9:0]       VGA_col,
   input  logic             frame_start,
   input  tile_type_t       tile_type [ROWS][COLS],
   input  logic [ROWS-1:0]  clear_rows,
   input  logic             clear_start,
   output logic             clear_busy,
   output logic             clear_done,
   output logic [23:0]      output_color,
   output logic             active
);

   localparam int unsigned CSW = (TILE_W > 1) ? $clog2(TILE_W) : 1;
   localparam int unsigned CIW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int unsigned RSW = (TILE_H > 1) ? $clog2(TILE_H) : 1;
   localparam int unsigned RIW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned FCW = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;
   localparam int unsigned TCW = (FLASH_TOGGLES > 1) ? $clog2(FLASH_TOGGLES) : 1;

   localparam logic [9:0]     HSTART_C = 10'(HSTART);
   localparam logic [9:0]     VSTART_C = 10'(VSTART);
   localparam logic [10:0]    HEND_C   = 11'(HSTART + COLS * TILE_W);
   localparam logic [10:0]    VEND_C   = 11'(VSTART + ROWS * TILE_H);
   localparam logic [CSW-1:0] CS_LAST  = CSW'(TILE_W - 1);
   localparam logic [RSW-1:0] RS_LAST  = RSW'(TILE_H - 1);
   localparam logic [FCW-1:0] FC_LAST  = FCW'(FLASH_PERIOD - 1);
   localparam logic [TCW-1:0] TC_LAST  = TCW'(FLASH_TOGGLES - 1);

   // ---------------- Stage 0: scan tracking ----------------
   logic [CSW-1:0] col_sub_q, col_sub_cur, col_sub_nxt;
   logic [CIW-1:0] col_idx_q, col_idx_cur, col_idx_nxt;
   logic [RSW-1:0] row_sub_q, row_sub_cur;
   logic [RIW-1:0] row_idx_q, row_idx_cur;
   logic           at_hstart, in_region;
   tile_type_t     tile_sel;

   assign at_hstart = (VGA_col == HSTART_C);
   assign in_region = (VGA_row >= VSTART_C) && ({1'b0, VGA_row} < VEND_C) &&
                      (VGA_col >= HSTART_C) && ({1'b0, VGA_col} < HEND_C);

   // The *_q counters hold the position of the current pixel unless this is the
   // first playfield column, where they are re-derived from the scan inputs.
   always_comb begin
      col_sub_cur = at_hstart ? '0 : col_sub_q;
      col_idx_cur = at_hstart ? '0 : col_idx_q;
      if (col_sub_cur == CS_LAST) begin
         col_sub_nxt = '0;
         col_idx_nxt = col_idx_cur + CIW'(1);
      end else begin
         col_sub_nxt = col_sub_cur + CSW'(1);
         col_idx_nxt = col_idx_cur;
      end
      row_sub_cur = row_sub_q;
      row_idx_cur = row_idx_q;
      if (at_hstart) begin
         if (VGA_row == VSTART_C) begin
            row_sub_cur = '0;
            row_idx_cur = '0;
         end else if (row_sub_q == RS_LAST) begin
            row_sub_cur = '0;
            row_idx_cur = row_idx_q + RIW'(1);
         end else begin
            row_sub_cur = row_sub_q + RSW'(1);
         end
      end
      tile_sel = TT_BLANK;
      if (in_region) tile_sel = tile_type[row_idx_cur][col_idx_cur];
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         col_sub_q <= '0;
         col_idx_q <= '0;
         row_sub_q <= '0;
         row_idx_q <= '0;
      end else begin
         col_sub_q <= col_sub_nxt;
         col_idx_q <= col_idx_nxt;
         row_sub_q <= row_sub_cur;
         row_idx_q <= row_idx_cur;
      end
   end

   // ---------------- Stage 1 ----------------
   // The column index is consumed by the tile select, so only the row index
   // (needed for the flash mask) travels down the pipe.
   logic           s1_in_region_q;
   logic [RIW-1:0] s1_row_idx_q;
   tile_type_t     s1_tile_q;
`ifdef PLAYFIELD_GRID_LINES_EN
   logic           s1_edge_q;
`endif

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         s1_in_region_q <= 1'b0;
         s1_row_idx_q   <= '0;
         s1_tile_q      <= TT_BLANK;
`ifdef PLAYFIELD_GRID_LINES_EN
         s1_edge_q      <= 1'b0;
`endif
      end else begin
         s1_in_region_q <= in_region;
         s1_row_idx_q   <= row_idx_cur;
         s1_tile_q      <= tile_sel;
`ifdef PLAYFIELD_GRID_LINES_EN
         s1_edge_q      <= (col_sub_cur == CS_LAST) || (row_sub_cur == RS_LAST);
`endif
      end
   end

   // ---------------- Clear animation FSM ----------------
   clear_state_t    state_q, state_d;
   logic [ROWS-1:0] mask_q, mask_d;
   logic [FCW-1:0]  frame_cnt_q, frame_cnt_d;
   logic [TCW-1:0]  toggle_cnt_q, toggle_cnt_d;
   logic            flash_on_q, flash_on_d;

   always_comb begin
      state_d      = state_q;
      mask_d       = mask_q;
      frame_cnt_d  = frame_cnt_q;
      toggle_cnt_d = toggle_cnt_q;
      flash_on_d   = flash_on_q;
      case (state_q)
         IDLE: begin
            if (clear_start) begin
               mask_d       = clear_rows;
               frame_cnt_d  = '0;
               toggle_cnt_d = '0;
               if (clear_rows == '0) begin
                  state_d = DONE;
               end else begin
                  flash_on_d = 1'b1;
                  state_d    = FLASH;
               end
            end
         end
         FLASH: begin
            if (frame_start) begin
               if (frame_cnt_q == FC_LAST) begin
                  frame_cnt_d  = '0;
                  toggle_cnt_d = toggle_cnt_q + TCW'(1);
                  if (toggle_cnt_q == TC_LAST) begin
                     flash_on_d = 1'b0;
                     state_d    = DONE;
                  end else begin
                     flash_on_d = ~flash_on_q;
                  end
               end else begin
                  frame_cnt_d = frame_cnt_q + FCW'(1);
               end
            end
         end
         DONE: begin
            mask_d     = '0;
            flash_on_d = 1'b0;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q      <= IDLE;
         mask_q       <= '0;
         frame_cnt_q  <= '0;
         toggle_cnt_q <= '0;
         flash_on_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         mask_q       <= mask_d;
         frame_cnt_q  <= frame_cnt_d;
         toggle_cnt_q <= toggle_cnt_d;
         flash_on_q   <= flash_on_d;
      end
   end

   assign clear_busy = (state_q != IDLE);
   assign clear_done = (state_q == DONE);

   // ---------------- Stage 2: colour ----------------
   logic [23:0] lut_color, color_d;

   tile_color_lut u_lut (
      .tile  (s1_tile_q),
      .color (lut_color)
   );

   always_comb begin
      color_d = TILE_BLANK_COLOR;
      if (s1_in_region_q) begin
         if (flash_on_q && mask_q[s1_row_idx_q]) color_d = TILE_FLASH_COLOR;
         else                                    color_d = lut_color;
`ifdef PLAYFIELD_GRID_LINES_EN
         if (s1_edge_q) color_d = TILE_GRID_COLOR;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         output_color <= TILE_BLANK_COLOR;
         active       <= 1'b0;
      end else begin
         output_color <= color_d;
         active       <= s1_in_region_q;
      end
   end

endmodule

// File: tb/tb_playfield_pixel_pipe.sv
// Directed self-checking bench for playfield_pixel_pipe (default parameters).
module tb_playfield_pixel_pipe;
   import playfield_pixel_pipe_pkg::*;

   localparam int unsigned ROWS = 20;
   localparam int unsigned COLS = 10;

   logic            clk = 1'b0;
   logic            rst_l;
   logic [9:0]      VGA_row, VGA_col;
   logic            frame_start, clear_start;
   tile_type_t      tile_type [ROWS][COLS];
   logic [ROWS-1:0] clear_rows;
   logic            clear_busy, clear_done, active;
   logic [23:0]     output_color;

   int n_cmp = 0;
   int n_err = 0;

   playfield_pixel_pipe dut (
      .clk          (clk),
      .rst_l        (rst_l),
      .VGA_row      (VGA_row),
      .VGA_col      (VGA_col),
      .frame_start  (frame_start),
      .tile_type    (tile_type),
      .clear_rows   (clear_rows),
      .clear_start  (clear_start),
      .clear_busy   (clear_busy),
      .clear_done   (clear_done),
      .output_color (output_color),
      .active       (active)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Present one pixel and step one clock; outputs then reflect the previous pixel.
   task automatic pix(input int r, input int c);
      VGA_row = 10'(r);
      VGA_col = 10'(c);
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_frame();
      frame_start = 1'b1;
      pix(0, 0);
      frame_start = 1'b0;
   endtask

   // Last pixel column/row of a tile turns into a grid line when enabled.
   function automatic logic [23:0] edge_color(input logic [23:0] c);
`ifdef PLAYFIELD_GRID_LINES_EN
      return TILE_GRID_COLOR;
`else
      return c;
`endif
   endfunction

   // Walk rows 40..420 at the first column, then read pixel (420,220): tile row 19.
   task automatic scan_row19(input string tag, input logic [23:0] exp);
      for (int r = 40; r <= 420; r++) pix(r, 220);
      pix(0, 0);
      check(tag, 32'(output_color), 32'(exp));
   endtask

   task automatic scan_row0(input string tag, input logic [23:0] exp);
      pix(40, 220);
      pix(0, 0);
      check(tag, 32'(output_color), 32'(exp));
   endtask

   logic done_seen;

   initial begin
      rst_l       = 1'b0;
      VGA_row     = '0;
      VGA_col     = '0;
      frame_start = 1'b0;
      clear_start = 1'b0;
      clear_rows  = '0;
      for (int r = 0; r < ROWS; r++)
         for (int c = 0; c < COLS; c++) tile_type[r][c] = TT_BLANK;
      tile_type[0][0]  = TT_I;
      tile_type[0][9]  = TT_O;
      tile_type[19][0] = TT_T;
      tile_type[3][4]  = TT_Z;
      tile_type[3][5]  = TT_S;
      tile_type[3][6]  = tile_type_t'(4'd13);

      #12;
      check("rst_color", 32'(output_color), 32'(TILE_BLANK_COLOR));
      check("rst_active", 32'(active), 32'd0);
      check("rst_busy", 32'(clear_busy), 32'd0);
      check("rst_done", 32'(clear_done), 32'd0);
      @(posedge clk);
      #1;
      rst_l = 1'b1;

      // First playfield pixel, two clocks of latency.
      scan_row0("first_pix_color", TETROMINO_I_COLOR);
      check("first_pix_active", 32'(active), 32'd1);

      // Horizontal boundary along row 40.
      for (int c = 220; c <= 420; c++) pix(40, c);
      check("col419_active", 32'(active), 32'd1);
      check("col419_color", 32'(output_color), 32'(edge_color(TETROMINO_O_COLOR)));
      pix(0, 0);
      check("col420_active", 32'(active), 32'd0);
      check("col420_color", 32'(output_color), 32'(TILE_BLANK_COLOR));

      // Vertical boundary at column 220.
      for (int r = 41; r <= 440; r++) pix(r, 220);
      check("row439_active", 32'(active), 32'd1);
      check("row439_color", 32'(output_color), 32'(edge_color(TETROMINO_T_COLOR)));
      pix(0, 0);
      check("row440_active", 32'(active), 32'd0);
      check("row440_color", 32'(output_color), 32'(TILE_BLANK_COLOR));

      // Tile boundary on row 100 (tile row 3): col 319 in tile 4, col 320 in tile 5.
      for (int r = 40; r <= 100; r++) pix(r, 220);
      for (int c = 221; c <= 320; c++) pix(100, c);
      check("col319_z", 32'(output_color), 32'(edge_color(TETROMINO_Z_COLOR)));
      pix(0, 0);
      check("col320_s", 32'(output_color), 32'(TETROMINO_S_COLOR));

      // Unknown tile encoding renders blank but still inside the playfield.
      for (int c = 220; c <= 340; c++) pix(101, c);
      pix(0, 0);
      check("unknown_color", 32'(output_color), 32'(TILE_BLANK_COLOR));
      check("unknown_active", 32'(active), 32'd1);

      // Grid line at the last column of tile (0,0).
      for (int c = 220; c <= 239; c++) pix(40, c);
      pix(0, 0);
      check("col239_grid", 32'(output_color), 32'(edge_color(TETROMINO_I_COLOR)));

      // Clear animation on row 19; start and first frame_start coincide.
      clear_rows  = 20'h80000;
      clear_start = 1'b1;
      frame_start = 1'b1;
      pix(0, 0);
      clear_start = 1'b0;
      frame_start = 1'b0;
      check("clr_busy", 32'(clear_busy), 32'd1);
      scan_row19("flash_f0", TILE_FLASH_COLOR);
      scan_row0("row0_f0_normal", TETROMINO_I_COLOR);
      for (int f = 1; f <= 48; f++) begin
         pulse_frame();
         if (f == 7)  scan_row19("flash_f7", TILE_FLASH_COLOR);
         if (f == 8)  scan_row19("normal_f8", TETROMINO_T_COLOR);
         if (f == 15) scan_row19("normal_f15", TETROMINO_T_COLOR);
         if (f == 16) scan_row19("flash_f16", TILE_FLASH_COLOR);
         if (f == 20) begin
            clear_rows  = 20'h00001;
            clear_start = 1'b1;
            pix(0, 0);
            clear_start = 1'b0;
            clear_rows  = 20'h80000;
            check("restart_busy", 32'(clear_busy), 32'd1);
            scan_row0("restart_ignored", TETROMINO_I_COLOR);
            scan_row19("flash_f20", TILE_FLASH_COLOR);
         end
         if (f == 24) scan_row19("normal_f24", TETROMINO_T_COLOR);
         if (f == 47) begin
            check("done_f47", 32'(clear_done), 32'd0);
            check("busy_f47", 32'(clear_busy), 32'd1);
         end
      end
      check("done_pulse", 32'(clear_done), 32'd1);
      check("done_busy", 32'(clear_busy), 32'd1);
      pix(0, 0);
      check("after_done", 32'(clear_done), 32'd0);
      check("after_busy", 32'(clear_busy), 32'd0);
      scan_row19("after_clear", TETROMINO_T_COLOR);

      // Empty mask goes straight to the done pulse.
      clear_rows  = '0;
      clear_start = 1'b1;
      pix(0, 0);
      clear_start = 1'b0;
      check("empty_done", 32'(clear_done), 32'd1);
      pix(0, 0);
      check("empty_done_end", 32'(clear_done), 32'd0);
      check("empty_busy_end", 32'(clear_busy), 32'd0);

      // Reset mid-animation aborts without a done pulse.
      clear_rows  = 20'h80000;
      clear_start = 1'b1;
      pix(0, 0);
      clear_start = 1'b0;
      for (int f = 0; f < 3; f++) pulse_frame();
      check("abort_busy_before", 32'(clear_busy), 32'd1);
      #2;
      rst_l = 1'b0;
      #1;
      check("abort_busy", 32'(clear_busy), 32'd0);
      check("abort_done", 32'(clear_done), 32'd0);
      @(posedge clk);
      #1;
      rst_l = 1'b1;
      done_seen = 1'b0;
      for (int f = 0; f < 60; f++) begin
         pulse_frame();
         if (clear_done) done_seen = 1'b1;
      end
      check("abort_no_done", 32'(done_seen), 32'd0);
      scan_row19("abort_no_flash", TETROMINO_T_COLOR);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
